// File: rtl/m_cp0_pkg.sv
// rtl/m_cp0_pkg.sv - CP0 register numbers, exception codes and SR/Cause bit positions
package m_cp0_pkg;

   localparam int HWINT_W = 6;
   localparam int EXC_W   = 5;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;

   typedef enum logic [EXC_W-1:0] {
      EXC_INT     = 5'd0,
      EXC_ADEL    = 5'd4,
      EXC_ADES    = 5'd5,
      EXC_SYSCALL = 5'd8,
      EXC_RI      = 5'd10,
      EXC_OV      = 5'd12
   } excCode_e;

   localparam int SR_IE       = 0;
   localparam int SR_EXL      = 1;
   localparam int SR_IM_LO    = 10;
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_IP_LO = 10;
   localparam int CAUSE_BD    = 31;

endpackage

// File: rtl/m_cp0_if.sv
// rtl/m_cp0_if.sv - M-stage pipeline <-> CP0 signal bundle
interface m_cp0_if
   import m_cp0_pkg::*;
();
   logic [4:0]         A;
   logic [31:0]        DIn;
   logic               WE;
   logic [31:0]        PC;
   logic               BDIn;
   logic [EXC_W-1:0]   ExcCodeIn;
   logic [HWINT_W-1:0] HWInt;
   logic               EXLClr;
   logic               Req;
   logic [31:0]        EPCOut;
   logic [31:0]        DOut;

   modport master (
      output A, DIn, WE, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
      input  Req, EPCOut, DOut
   );

   modport slave (
      input  A, DIn, WE, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
      output Req, EPCOut, DOut
   );
endinterface

// File: rtl/m_cp0_exc_arbiter.sv
// rtl/m_cp0_exc_arbiter.sv - interrupt/exception request and ExcCode select
// An enabled interrupt outranks any synchronous exception of the same instruction.
module cp0_exc_arbiter
   import m_cp0_pkg::*;
(
   input  logic [HWINT_W-1:0] hwInt,
   input  logic [HWINT_W-1:0] im,
   input  logic               ie,
   input  logic               exl,
   input  logic [EXC_W-1:0]   excCodeIn,
   output logic               anyReq,
   output logic [EXC_W-1:0]   excCodeSel
);
   logic intReq;
   logic excReq;

   assign intReq     = (|(hwInt & im)) & ie & ~exl;
   assign excReq     = (excCodeIn != '0) & ~exl;
   assign anyReq     = intReq | excReq;
   assign excCodeSel = intReq ? EXC_INT : excCodeIn;
endmodule

// File: rtl/m_cp0.sv
// rtl/m_cp0.sv - M-stage coprocessor 0: SR/Cause/EPC, trap request, mfc0/mtc0/eret
module m_cp0
   import m_cp0_pkg::*;
(
   input logic     clk,
   input logic     reset,
   m_cp0_if.slave  bus
);
   logic [HWINT_W-1:0] im;
   logic               exl;
   logic               ie;
   logic               bd;
   logic [HWINT_W-1:0] ip;
   logic [EXC_W-1:0]   excCode;
   logic [31:0]        epc;

   logic               anyReq;
   logic               req;
   logic [EXC_W-1:0]   excCodeSel;
   logic [31:0]        pcAdj;
   logic               mtc0;
   logic [31:0]        srImg;
   logic [31:0]        causeImg;

   cp0_exc_arbiter uArb (
      .hwInt      (bus.HWInt),
      .im         (im),
      .ie         (ie),
      .exl        (exl),
      .excCodeIn  (bus.ExcCodeIn),
      .anyReq     (anyReq),
      .excCodeSel (excCodeSel)
   );

   assign req   = ~reset & anyReq;
   assign pcAdj = bus.BDIn ? (bus.PC - 32'd4) : bus.PC;
   assign mtc0  = bus.WE & ~req;

   // Trap updates take precedence; otherwise mtc0 lands first and eret clears EXL last.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im      <= '0;
         exl     <= 1'b0;
         ie      <= 1'b0;
         bd      <= 1'b0;
         ip      <= '0;
         excCode <= '0;
         epc     <= '0;
      end else begin
         ip <= bus.HWInt;
         if (req) begin
            exl     <= 1'b1;
            excCode <= excCodeSel;
            bd      <= bus.BDIn;
            epc     <= pcAdj & 32'hFFFF_FFFC;
         end else begin
            if (mtc0 && bus.A == CP0_SR) begin
               im  <= bus.DIn[SR_IM_LO +: HWINT_W];
               exl <= bus.DIn[SR_EXL];
               ie  <= bus.DIn[SR_IE];
            end
            if (mtc0 && bus.A == CP0_EPC)
               epc <= bus.DIn & 32'hFFFF_FFFC;
            if (bus.EXLClr)
               exl <= 1'b0;
         end
      end
   end

   always_comb begin
      srImg = '0;
      srImg[SR_IM_LO +: HWINT_W] = im;
      srImg[SR_EXL] = exl;
      srImg[SR_IE]  = ie;
      causeImg = '0;
      causeImg[CAUSE_BD] = bd;
      causeImg[CAUSE_IP_LO +: HWINT_W] = ip;
      causeImg[CAUSE_EXC_LO +: EXC_W]  = excCode;
   end

   always_comb begin
      bus.DOut = '0;
      case (bus.A)
         CP0_SR:    bus.DOut = srImg;
         CP0_CAUSE: bus.DOut = causeImg;
         CP0_EPC:   bus.DOut = epc;
         default:   bus.DOut = '0;
      endcase
   end

   assign bus.Req    = req;
   assign bus.EPCOut = epc;
endmodule

// File: tb/tb_m_cp0.sv
// tb/tb_m_cp0.sv - self-checking bench for m_cp0
module tb_m_cp0;
   import m_cp0_pkg::*;

   logic clk;
   logic reset;

   m_cp0_if bus();

   m_cp0 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] din;
      logic        we;
      logic [31:0] pc;
      logic        bd;
      logic [4:0]  exc;
      logic [5:0]  hw;
      logic        eclr;
      logic        req;
      logic [31:0] sr;
      logic [31:0] cause;
      logic [31:0] epc;
   } vec_t;

   typedef struct {
      logic        req;
      logic [31:0] sr;
      logic [31:0] cause;
      logic [31:0] epc;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      bus.A = a;
      #1;
      d = bus.DOut;
   endtask

   task automatic addVec(input logic [4:0] a, input logic [31:0] din, input logic we,
                         input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                         input logic [5:0] hw, input logic eclr, input logic req,
                         input logic [31:0] sr, input logic [31:0] cause, input logic [31:0] epc);
      vec_t v;
      v.a = a; v.din = din; v.we = we; v.pc = pc; v.bd = bd; v.exc = exc;
      v.hw = hw; v.eclr = eclr; v.req = req; v.sr = sr; v.cause = cause; v.epc = epc;
      tbl.push_back(v);
   endtask

   task automatic idleInputs();
      bus.A = 5'd0; bus.DIn = '0; bus.WE = 1'b0; bus.PC = '0; bus.BDIn = 1'b0;
      bus.ExcCodeIn = '0; bus.HWInt = '0; bus.EXLClr = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      exp_t        e;

      idleInputs();
      reset = 1'b0;
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rd(CP0_SR, d);    chk("reset_sr", d, 32'h0);
      rd(CP0_CAUSE, d); chk("reset_cause", d, 32'h0);
      rd(CP0_EPC, d);   chk("reset_epc", d, 32'h0);
      chk("reset_req", {31'b0, bus.Req}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      //      a      din           we  pc            bd  exc     hw         eclr req  sr            cause         epc
      addVec(5'd12, 32'h00000401, 1, 32'h00003000, 0, 5'd0,  6'b000000, 0,   0, 32'h00000401, 32'h00000000, 32'h00000000);
      addVec(5'd0,  32'h0,        0, 32'h00003010, 0, 5'd0,  6'b000001, 0,   1, 32'h00000403, 32'h00000400, 32'h00003010);
      addVec(5'd0,  32'h0,        0, 32'h00003014, 0, 5'd8,  6'b000000, 0,   0, 32'h00000403, 32'h00000000, 32'h00003010);
      addVec(5'd0,  32'h0,        0, 32'h00003014, 0, 5'd8,  6'b000000, 1,   0, 32'h00000401, 32'h00000000, 32'h00003010);
      addVec(5'd0,  32'h0,        0, 32'h00003018, 0, 5'd8,  6'b000000, 0,   1, 32'h00000403, 32'h00000020, 32'h00003018);
      addVec(5'd0,  32'h0,        0, 32'h0000301C, 0, 5'd0,  6'b000000, 1,   0, 32'h00000401, 32'h00000020, 32'h00003018);
      addVec(5'd12, 32'h00000000, 1, 32'h0000301C, 0, 5'd0,  6'b000000, 0,   0, 32'h00000000, 32'h00000020, 32'h00003018);
      addVec(5'd0,  32'h0,        0, 32'h00003020, 1, 5'd12, 6'b000000, 0,   1, 32'h00000002, 32'h80000030, 32'h0000301C);
      addVec(5'd0,  32'h0,        0, 32'h00003024, 0, 5'd0,  6'b000000, 1,   0, 32'h00000000, 32'h80000030, 32'h0000301C);
      addVec(5'd12, 32'h00000401, 1, 32'h00003028, 0, 5'd0,  6'b000000, 0,   0, 32'h00000401, 32'h80000030, 32'h0000301C);
      addVec(5'd0,  32'h0,        0, 32'h00003040, 0, 5'd10, 6'b000001, 0,   1, 32'h00000403, 32'h00000400, 32'h00003040);
      addVec(5'd0,  32'h0,        0, 32'h00003044, 0, 5'd0,  6'b000000, 1,   0, 32'h00000401, 32'h00000000, 32'h00003040);
      addVec(5'd14, 32'h00003007, 1, 32'h00003048, 0, 5'd0,  6'b000000, 0,   0, 32'h00000401, 32'h00000000, 32'h00003004);
      addVec(5'd14, 32'h00005000, 1, 32'h00003050, 0, 5'd4,  6'b000000, 0,   1, 32'h00000403, 32'h00000010, 32'h00003050);
      addVec(5'd12, 32'h0000FC03, 1, 32'h00003054, 0, 5'd0,  6'b000000, 1,   0, 32'h0000FC01, 32'h00000010, 32'h00003050);
      addVec(5'd13, 32'hFFFFFFFF, 1, 32'h00003058, 0, 5'd0,  6'b000000, 0,   0, 32'h0000FC01, 32'h00000010, 32'h00003050);
      addVec(5'd0,  32'h0,        0, 32'h00000000, 1, 5'd5,  6'b000000, 0,   1, 32'h0000FC03, 32'h80000014, 32'hFFFFFFFC);
      addVec(5'd0,  32'h0,        0, 32'h00003060, 0, 5'd0,  6'b101010, 0,   0, 32'h0000FC03, 32'h8000A814, 32'hFFFFFFFC);
      addVec(5'd0,  32'h0,        0, 32'h00003060, 0, 5'd0,  6'b101010, 1,   0, 32'h0000FC01, 32'h8000A814, 32'hFFFFFFFC);
      addVec(5'd0,  32'h0,        0, 32'h00003060, 0, 5'd0,  6'b101010, 0,   1, 32'h0000FC03, 32'h0000A800, 32'h00003060);
      addVec(5'd20, 32'h00001234, 1, 32'h00003064, 0, 5'd0,  6'b000000, 1,   0, 32'h0000FC01, 32'h00000000, 32'h00003060);

      foreach (tbl[i]) begin
         @(negedge clk);
         bus.A = tbl[i].a; bus.DIn = tbl[i].din; bus.WE = tbl[i].we; bus.PC = tbl[i].pc;
         bus.BDIn = tbl[i].bd; bus.ExcCodeIn = tbl[i].exc; bus.HWInt = tbl[i].hw;
         bus.EXLClr = tbl[i].eclr;
         sb.push_back('{req: tbl[i].req, sr: tbl[i].sr, cause: tbl[i].cause, epc: tbl[i].epc});
         #1;
         e = sb.pop_front();
         chk($sformatf("v%0d_req", i), {31'b0, bus.Req}, {31'b0, e.req});
         @(posedge clk);
         #1;
         bus.WE = 1'b0;
         bus.EXLClr = 1'b0;
         rd(CP0_SR, d);    chk($sformatf("v%0d_sr", i), d, e.sr);
         rd(CP0_CAUSE, d); chk($sformatf("v%0d_cause", i), d, e.cause);
         rd(CP0_EPC, d);   chk($sformatf("v%0d_epc", i), d, e.epc);
         chk($sformatf("v%0d_epcout", i), bus.EPCOut, e.epc);
      end

      // Unmapped register reads zero; then reset mid-cycle with a pending Ov.
      @(negedge clk);
      idleInputs();
      rd(5'd20, d); chk("rd_unmapped", d, 32'h0);
      bus.ExcCodeIn = EXC_OV;
      #1;
      chk("pre_reset_req", {31'b0, bus.Req}, 32'h1);
      reset = 1'b1;
      #1;
      chk("async_reset_req", {31'b0, bus.Req}, 32'h0);
      rd(CP0_SR, d);    chk("async_reset_sr", d, 32'h0);
      rd(CP0_CAUSE, d); chk("async_reset_cause", d, 32'h0);
      rd(CP0_EPC, d);   chk("async_reset_epc", d, 32'h0);
      chk("async_reset_epcout", bus.EPCOut, 32'h0);
      @(negedge clk);
      idleInputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/m_cp0.md
Name: m_cp0

Overview:
- Coprocessor-0 exception/interrupt responder at the M stage of the five-stage MIPS pipeline.
- Consumes the exception codes raised upstream: ALU arithmetic overflow (Ov), ALU address-calculation overflow mapped to AdEL/AdES, RI, Syscall, and fetch AdEL.
- Also consumes six external hardware interrupt lines.
- Holds SR, Cause and EPC; produces the flush/redirect request to the pipeline; serves mfc0/mtc0/eret.

Parameters:
- HWINT_W, 6, number of hardware interrupt lines; mapped to Cause.IP and SR.IM bits [15:10].
- EXC_W, 5, width of the exception code field.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all CP0 state immediately.
- A  in  5  CP0 register number for both the mfc0 read and the mtc0 write.
- DIn  in  32  mtc0 write data (rt value from M stage).
- WE  in  1  mtc0 write enable.
- PC  in  32  PC of the M-stage instruction (macro PC on bubbles).
- BDIn  in  1  M-stage instruction sits in a branch delay slot.
- ExcCodeIn  in  5  pending exception code of the M-stage instruction; 0 means none.
- HWInt  in  6  external interrupt lines, level-sensitive.
- EXLClr  in  1  eret in M stage.
- Req  out  1  take exception/interrupt now: flush pipeline, redirect to the handler.
- EPCOut  out  32  current EPC register, the eret target.
- DOut  out  32  mfc0 read data.

Behaviour:
- Registers:
  - SR(12): IM = bits[15:10], EXL = bit1, IE = bit0; all other bits read 0.
  - Cause(13): BD = bit31, IP = bits[15:10], ExcCode = bits[6:2]; all other bits read 0.
  - EPC(14): 32 bits, bits[1:0] always 0.
- Reset, asynchronous: SR, Cause and EPC all go to 0; Req = 0 while reset is high; DOut and EPCOut read 0.
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- ExcReq = (ExcCodeIn != 0) & ~SR.EXL.
- Req = ~reset & (IntReq | ExcReq). Combinational, same cycle, zero latency.
- Priority: an interrupt beats a synchronous exception. On IntReq the latched ExcCode is 0, even if ExcCodeIn != 0.
- On the clock edge with Req = 1:
  - EXL <= 1.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
  - Cause.BD <= BDIn.
  - EPC <= (BDIn ? PC - 4 : PC) with bits[1:0] forced to 0.
- Cause.IP <= HWInt on every edge, independent of Req and EXL.
- mtc0 (WE & ~Req):
  - A == 12 writes SR (IM, EXL, IE only).
  - A == 14 writes EPC with bits[1:0] cleared.
  - Cause and all other numbers are read-only; writes are ignored.
- Req and WE in the same cycle: the mtc0 is dropped and Req updates win.
- EXLClr: EXL <= 0 on the edge.
- EXLClr while EXL = 1 means Req cannot fire that cycle (Req needs ~EXL), so there is no conflict. EXLClr with Req = 1 cannot occur legally; if it does, Req wins and EXL = 1.
- mtc0 to SR in the same cycle as EXLClr: the mtc0 value is written, then EXL is cleared.
- DOut: combinational on A; 12/13/14 return the register image; every other number returns 0. The read returns the pre-edge value; there is no write-through bypass.
- Nested events: while EXL = 1, all exceptions and interrupts are masked; the pending HWInt still shows in Cause.IP.
- PC - 4 wraps modulo 2^32 (PC = 0 in a delay slot gives 0xFFFFFFFC).

Decomposition:
- Shared package (macro.v defines):
  - CP0 register numbers SR = 12, CAUSE = 13, EPC = 14.
  - ExcCodes: Int = 0, AdEL = 4, AdES = 5, Syscall = 8, RI = 10, Ov = 12.
  - SR/Cause bit-position constants.
- One natural sub-module: cp0_exc_arbiter, the combinational IntReq/ExcReq/priority/ExcCode select. Registers stay in m_cp0.

Test Plan:
- Reset high mid-run with SR = 0x0000FC01 → SR, Cause, EPC read 0 the same cycle; Req = 0 even with ExcCodeIn = 12.
- SR = 0x00000401, HWInt = 6'b000001, PC = 0x3010, BDIn = 0 → Req = 1; after the edge EPC = 0x3010, Cause = 0x00000400, SR.EXL = 1.
- SR = 0, ExcCodeIn = 12 (Ov), PC = 0x3020, BDIn = 1 → Req = 1; EPC = 0x301C, Cause = 0x80000030.
- Both events together: SR = 0x00000401, HWInt[0] = 1, ExcCodeIn = 10 → Cause.ExcCode = 0 (interrupt wins).
- With EXL = 1, apply ExcCodeIn = 8 → Req = 0. Then EXLClr one cycle → EXL = 0, and the next cycle Req = 1 if still pending.
- WE = 1, A = 14, DIn = 0x3007 with no Req → EPC reads 0x3004. Repeat with Req = 1 → EPC = trapped PC, the write is dropped. WE to A = 13 → Cause unchanged.
